alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Integer execution unit on the consumer end of the ALU reservation station's issue bundle.
- Accepts one issued RV32I integer instruction per cycle with operands already resolved and computes its result.
- Queues results in a small FIFO and broadcasts them on the ALU CDB channel under an external CDB grant.
- Feeds back a stall to the reservation station so that no issued instruction is ever lost.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >=4)
- TAG_W, 4, ROB tag width
- OP_W, 6, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction rollback; discards all queued and incoming work
- in_valid  in  1  issue strobe from ALU reservation station
- in_op  in  OP_W  operation code (encoding below)
- in_reg1  in  32  rs1 value
- in_reg2  in  32  rs2 value
- in_imm  in  32  sign/shift-extended immediate
- in_pc  in  32  instruction PC
- in_dest_tag  in  TAG_W  ROB tag of destination
- alu_stall  out  1  to RS: hold issue
- cdb_valid  out  1  ALU CDB broadcast valid
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_data  out  32  broadcast result
- cdb_grant  in  1  CDB arbiter accepted current broadcast this cycle
- overflow_err  out  1  sticky: an issue arrived while FIFO full

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, head/tail/count=0, overflow_err=0. Consequently cdb_valid=0, cdb_tag=0, cdb_data=0, alu_stall=0. Reset overrides flush, rdy and all inputs.
- Opcodes:
  - 1 LUI=imm; 2 AUIPC=pc+imm; 3 JAL=pc+4; 4 JALR=pc+4
  - 5 ADDI; 6 SLTI; 7 SLTIU; 8 XORI; 9 ORI; 10 ANDI; 11 SLLI; 12 SRLI; 13 SRAI
  - 14 ADD; 15 SUB; 16 SLL; 17 SLT; 18 SLTU; 19 XOR; 20 SRL; 21 SRA; 22 OR; 23 AND
  - Immediate forms use in_imm as operand 2; register forms use in_reg2.
  - Any other code yields result 0 and is still broadcast.
- Arithmetic:
  - 32-bit wrap-around add/sub.
  - Shift amount is operand2[4:0]; SRA/SRAI sign-fill.
  - SLT/SLTI signed compare; SLTU/SLTIU unsigned compare; result 1 or 0.
- Push: at posedge with rdy=1, flush=0 and in_valid=1, the computed {tag,result} is written at tail; tail advances modulo DEPTH.
- CDB outputs are combinational from the head entry:
  - cdb_valid = (count!=0); cdb_tag and cdb_data show the head entry when count!=0, else 0.
- Pop: at posedge with rdy=1, flush=0, cdb_valid=1 and cdb_grant=1, head advances modulo DEPTH. A grant with count=0 is ignored.
- Latency: issue captured at edge N; the result is visible on the CDB after edge N (empty FIFO) and can retire at edge N+1 if granted.
- Throughput: one result per cycle with continuous grant.
- Simultaneous push+pop:
  - count unchanged; legal at any occupancy, including full.
  - count=1 with push+pop: the new entry becomes head next cycle.
- Full, push without pop: the entry is dropped and overflow_err is set to 1 (sticky until reset); count stays DEPTH.
- alu_stall = (count >= DEPTH-2), combinational. This covers the registered one-cycle issue delay in the RS.
- Flush at posedge with rdy=1:
  - head=tail=count=0; the same-cycle in_valid is discarded and no pop is counted.
  - cdb_valid=0 after the edge.
  - overflow_err is unaffected.
- rdy=0: no push, no pop, no flush effect; outputs reflect held state.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset then idle: cdb_valid=0, alu_stall=0, overflow_err=0. Issue ADD 5+7, tag 3, grant=1 → next cycle cdb_valid=1, tag=3, data=12, then empty.
- Op sweep with grant=1:
  - SUB 0-1 → 0xFFFFFFFF
  - SRA 0x80000000>>4 → 0xF8000000
  - SLT -1<1 → 1; SLTU -1<1 → 0
  - AUIPC pc=0x1000, imm=0x2000 → 0x3000
  - JALR pc=0x40 → 0x44
  - SLLI shamt imm=0x21 → shift by 1
- Backpressure: grant=0, issue tags 1,2,3 back-to-back → alu_stall rises when count=2. Raise grant → tags 1,2,3 broadcast in order on consecutive cycles.
- Full: grant=0, push 4 entries, then push tag 9 → overflow_err=1 and count stays 4. Push with grant=1 at full → accepted, count stays 4, and the wrapped tail yields correct order.
- Flush with 3 queued entries and concurrent in_valid → next cycle cdb_valid=0, count=0; later issue tag 5 broadcasts normally.
- rdy=0 for 3 cycles with grant=1 and count=2 → head held, outputs stable; rdy=1 resumes draining.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execution unit: computes RV32I ALU results for issued instructions,
// buffers them in a small FIFO and broadcasts them on the ALU CDB under grant.
module alu_exec_unit #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4,
   parameter int OP_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [OP_W-1:0]  in_op,
   input  logic [31:0]      in_reg1,
   input  logic [31:0]      in_reg2,
   input  logic [31:0]      in_imm,
   input  logic [31:0]      in_pc,
   input  logic [TAG_W-1:0] in_dest_tag,
   output logic             alu_stall,
   output logic             cdb_valid,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [31:0]      cdb_data,
   input  logic             cdb_grant,
   output logic             overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [OP_W-1:0] {
      OP_LUI   = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL  = OP_W'(3),  OP_JALR = OP_W'(4),
      OP_ADDI  = OP_W'(5),  OP_SLTI  = OP_W'(6),  OP_SLTIU = OP_W'(7), OP_XORI = OP_W'(8),
      OP_ORI   = OP_W'(9),  OP_ANDI  = OP_W'(10), OP_SLLI = OP_W'(11), OP_SRLI = OP_W'(12),
      OP_SRAI  = OP_W'(13), OP_ADD   = OP_W'(14), OP_SUB  = OP_W'(15), OP_SLL  = OP_W'(16),
      OP_SLT   = OP_W'(17), OP_SLTU  = OP_W'(18), OP_XOR  = OP_W'(19), OP_SRL  = OP_W'(20),
      OP_SRA   = OP_W'(21), OP_OR    = OP_W'(22), OP_AND  = OP_W'(23)
   } op_e;

   logic [31:0]      op2;
   logic [4:0]       shamt;
   logic [31:0]      result;

   logic [TAG_W-1:0] tag_mem  [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic             full, active, do_pop, do_push, drop;

   // NOTE: every output of an always_comb gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      op2    = in_reg2;
      result = '0;
      if (in_op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                        OP_SLLI, OP_SRLI, OP_SRAI})
         op2 = in_imm;
      shamt = op2[4:0];
      case (in_op)
         OP_LUI:             result = in_imm;
         OP_AUIPC:           result = in_pc + in_imm;
         OP_JAL, OP_JALR:    result = in_pc + 32'd4;
         OP_ADDI, OP_ADD:    result = in_reg1 + op2;
         OP_SUB:             result = in_reg1 - op2;
         OP_SLTI, OP_SLT:    result = {31'b0, $signed(in_reg1) < $signed(op2)};
         OP_SLTIU, OP_SLTU:  result = {31'b0, in_reg1 < op2};
         OP_XORI, OP_XOR:    result = in_reg1 ^ op2;
         OP_ORI, OP_OR:      result = in_reg1 | op2;
         OP_ANDI, OP_AND:    result = in_reg1 & op2;
         OP_SLLI, OP_SLL:    result = in_reg1 << shamt;
         OP_SRLI, OP_SRL:    result = in_reg1 >> shamt;
         OP_SRAI, OP_SRA:    result = $unsigned($signed(in_reg1) >>> shamt);
         default:            result = '0;
      endcase
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign cdb_valid = (count != '0);
   assign cdb_tag   = cdb_valid ? tag_mem[head]  : '0;
   assign cdb_data  = cdb_valid ? data_mem[head] : '0;
   // Two-entry margin absorbs the RS's registered issue path.
   assign alu_stall = (count >= CNT_W'(DEPTH - 2));

   assign active  = rdy && !flush;
   assign do_pop  = active && cdb_valid && cdb_grant;
   assign do_push = active && in_valid && (!full || do_pop);
   assign drop    = active && in_valid && full && !do_pop;

   // NOTE: storage is deliberately not reset; count gates every read, so
   // stale contents are never observable and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         tag_mem[tail]  <= in_dest_tag;
         data_mem[tail] <= result;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else if (rdy && flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PTR_W'(1);
         if (do_pop)  head <= head + PTR_W'(1);
         if (drop)    overflow_err <= 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected CDB broadcasts are queued at
// issue time and compared in order whenever the DUT retires an entry.
module tb_alu_exec_unit;

   localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4,
      ADDI = 6'd5, SLTIU = 6'd7, XORI = 6'd8, ORI = 6'd9, ANDI = 6'd10,
      SLLI = 6'd11, SRLI = 6'd12, SRAI = 6'd13, ADD = 6'd14, SUB = 6'd15,
      SLL = 6'd16, SLT = 6'd17, SLTU = 6'd18, XOR = 6'd19, SRL = 6'd20,
      SRA = 6'd21;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, in_valid, cdb_grant;
   logic [5:0]  in_op;
   logic [31:0] in_reg1, in_reg2, in_imm, in_pc;
   logic [3:0]  in_dest_tag;
   logic        alu_stall, cdb_valid, overflow_err;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;

   logic [35:0] sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   alu_exec_unit #(.DEPTH(4), .TAG_W(4), .OP_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
      .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
      .in_pc(in_pc), .in_dest_tag(in_dest_tag), .alu_stall(alu_stall),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_grant(cdb_grant), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: a retirement happens at the next posedge when these hold.
   always @(negedge clk) begin
      if (!rst && rdy && !flush && cdb_valid && cdb_grant) begin
         if (sb_q.size() == 0) begin
            check("cdb_spurious_valid", {31'b0, cdb_valid}, 32'd0);
         end else begin
            logic [35:0] e;
            e = sb_q.pop_front();
            check("cdb_tag", {28'b0, cdb_tag}, {28'b0, e[35:32]});
            check("cdb_data", cdb_data, e[31:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                        input logic [31:0] exp, input bit accept);
      in_valid    = 1'b1;
      in_op       = op;
      in_reg1     = r1;
      in_reg2     = r2;
      in_imm      = imm;
      in_pc       = pc;
      in_dest_tag = tag;
      if (accept) sb_q.push_back({tag, exp});
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      cdb_grant = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0 && !cdb_valid) break;
         step();
      end
      check(tag, {31'b0, (sb_q.size() == 0) && !cdb_valid}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
      in_op = '0; in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_pc = '0; in_dest_tag = '0;
      step(); step();
      rst = 1'b0;
      step();
      check("rst_cdb_valid", {31'b0, cdb_valid}, 32'd0);
      check("rst_cdb_tag", {28'b0, cdb_tag}, 32'd0);
      check("rst_cdb_data", cdb_data, 32'd0);
      check("rst_stall", {31'b0, alu_stall}, 32'd0);
      check("rst_overflow", {31'b0, overflow_err}, 32'd0);

      // Single ADD: visible right after the capture edge, gone one edge later.
      cdb_grant = 1'b1;
      issue(ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b1);
      check("add_valid", {31'b0, cdb_valid}, 32'd1);
      check("add_tag", {28'b0, cdb_tag}, 32'd3);
      check("add_data", cdb_data, 32'd12);
      step();
      check("add_empty", {31'b0, cdb_valid}, 32'd0);

      // Op sweep, back-to-back with continuous grant.
      issue(SUB,   32'd0,        32'd1,        32'd0,        32'd0,     4'd1,  32'hFFFF_FFFF, 1'b1);
      issue(SRA,   32'h8000_0000, 32'd4,       32'd0,        32'd0,     4'd2,  32'hF800_0000, 1'b1);
      issue(SLT,   32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0,     4'd3,  32'd1,         1'b1);
      issue(SLTU,  32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0,     4'd4,  32'd0,         1'b1);
      issue(AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000,  4'd5,  32'h3000,      1'b1);
      issue(JALR,  32'h55,       32'd0,        32'd8,        32'h40,    4'd6,  32'h44,        1'b1);
      issue(SLLI,  32'd3,        32'd9,        32'h21,       32'd0,     4'd7,  32'd6,         1'b1);
      issue(LUI,   32'd1,        32'd2,        32'hABCD_E000, 32'd0,    4'd8,  32'hABCD_E000, 1'b1);
      issue(JAL,   32'd0,        32'd0,        32'd0,        32'h100,   4'd9,  32'h104,       1'b1);
      issue(ADDI,  32'hFFFF_FFFF, 32'd100,     32'd2,        32'd0,     4'd10, 32'd1,         1'b1);
      issue(SLTIU, 32'd1,        32'd0,        32'hFFFF_FFFF, 32'd0,    4'd11, 32'd1,         1'b1);
      issue(XORI,  32'hF0F0_F0F0, 32'd0,       32'hFFFF_0000, 32'd0,    4'd12, 32'h0F0F_F0F0, 1'b1);
      issue(ORI,   32'h00F0,     32'hFFFF,     32'h0F00,     32'd0,     4'd13, 32'h0FF0,      1'b1);
      issue(ANDI,  32'hFF00_FF00, 32'hFFFF_FFFF, 32'h0FF0_0FF0, 32'd0,  4'd14, 32'h0F00_0F00, 1'b1);
      issue(SRAI,  32'h8000_0000, 32'd0,       32'd31,       32'd0,     4'd15, 32'hFFFF_FFFF, 1'b1);
      issue(SRLI,  32'h8000_0000, 32'd0,       32'h24,       32'd0,     4'd0,  32'h0800_0000, 1'b1);
      issue(SRL,   32'h8000_0000, 32'd4,       32'd0,        32'd0,     4'd1,  32'h0800_0000, 1'b1);
      issue(SLL,   32'd1,        32'h3F,       32'd0,        32'd0,     4'd2,  32'h8000_0000, 1'b1);
      issue(XOR,   32'hAAAA_5555, 32'hFFFF_FFFF, 32'd0,      32'd0,     4'd3,  32'h5555_AAAA, 1'b1);
      issue(SLT,   32'd5,        32'hFFFF_FFFD, 32'd0,       32'd0,     4'd4,  32'd0,         1'b1);
      issue(6'd0,  32'd5,        32'd7,        32'd9,        32'd4,     4'd5,  32'd0,         1'b1);
      issue(6'd24, 32'd5,        32'd7,        32'd9,        32'd4,     4'd6,  32'd0,         1'b1);
      drain("sweep_drained");

      // Backpressure: stall asserts once two entries are held.
      cdb_grant = 1'b0;
      issue(ADD, 32'd1, 32'd0, 32'd0, 32'd0, 4'd1, 32'd1, 1'b1);
      check("bp_stall_cnt1", {31'b0, alu_stall}, 32'd0);
      issue(ADD, 32'd2, 32'd0, 32'd0, 32'd0, 4'd2, 32'd2, 1'b1);
      check("bp_stall_cnt2", {31'b0, alu_stall}, 32'd1);
      issue(ADD, 32'd3, 32'd0, 32'd0, 32'd0, 4'd3, 32'd3, 1'b1);
      check("bp_stall_cnt3", {31'b0, alu_stall}, 32'd1);
      check("bp_head_tag", {28'b0, cdb_tag}, 32'd1);
      drain("bp_drained");

      // Full FIFO: a fifth push is dropped; push+pop at full is accepted.
      cdb_grant = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(ADDI, 32'd100, 32'd0, 32'(i), 32'd0, 4'(4 + i), 32'(100 + i), 1'b1);
      check("full_no_overflow_yet", {31'b0, overflow_err}, 32'd0);
      issue(ADD, 32'd9, 32'd9, 32'd0, 32'd0, 4'd9, 32'd18, 1'b0);
      check("full_overflow_set", {31'b0, overflow_err}, 32'd1);
      check("full_head_kept", {28'b0, cdb_tag}, 32'd4);
      cdb_grant = 1'b1;
      issue(ADD, 32'd10, 32'd0, 32'd0, 32'd0, 4'd10, 32'd10, 1'b1);
      cdb_grant = 1'b0;
      check("full_pushpop_stall", {31'b0, alu_stall}, 32'd1);
      check("full_pushpop_head", {28'b0, cdb_tag}, 32'd5);
      drain("full_drained");
      check("overflow_sticky", {31'b0, overflow_err}, 32'd1);

      // Flush with three queued entries and a concurrent issue.
      cdb_grant = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(ADD, 32'(i), 32'd0, 32'd0, 32'd0, 4'(1 + i), 32'(i), 1'b1);
      flush = 1'b1;
      cdb_grant = 1'b1;
      issue(ADD, 32'd8, 32'd0, 32'd0, 32'd0, 4'd8, 32'd8, 1'b0);
      flush = 1'b0;
      sb_q.delete();
      check("flush_cdb_valid", {31'b0, cdb_valid}, 32'd0);
      check("flush_stall", {31'b0, alu_stall}, 32'd0);
      check("flush_overflow_kept", {31'b0, overflow_err}, 32'd1);
      issue(ADD, 32'd20, 32'd22, 32'd0, 32'd0, 4'd5, 32'd42, 1'b1);
      check("post_flush_tag", {28'b0, cdb_tag}, 32'd5);
      drain("flush_drained");

      // rdy low: nothing moves, even with grant and an issue strobe present.
      cdb_grant = 1'b0;
      issue(SUB, 32'd50, 32'd8, 32'd0, 32'd0, 4'd11, 32'd42, 1'b1);
      issue(SUB, 32'd50, 32'd9, 32'd0, 32'd0, 4'd12, 32'd41, 1'b1);
      rdy = 1'b0;
      cdb_grant = 1'b1;
      in_valid = 1'b1; in_op = ADD; in_reg1 = 32'd7; in_reg2 = 32'd7; in_dest_tag = 4'd13;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_valid", {31'b0, cdb_valid}, 32'd1);
         check("hold_tag", {28'b0, cdb_tag}, 32'd11);
         check("hold_data", cdb_data, 32'd42);
      end
      in_valid = 1'b0;
      rdy = 1'b1;
      drain("hold_drained");

      // Reset clears the sticky error and any queued entries.
      cdb_grant = 1'b0;
      issue(ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1, 32'd2, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst2_overflow", {31'b0, overflow_err}, 32'd0);
      check("rst2_cdb_valid", {31'b0, cdb_valid}, 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
